// File: rtl/multicycle_seq_ctrl.sv
// Multicycle control sequencer: walks each instruction through FETCH/DECODE/REGRD/ALU/MEM/REGWR
// as its opcode class requires, with memory-wait timeout, global stall, halt/resume and retire counting.
module multicycle_seq_ctrl #(
  parameter int             OPW      = 4,
  parameter logic [OPW-1:0] OP_LOAD  = 4'h8,
  parameter logic [OPW-1:0] OP_STORE = 4'h9,
  parameter logic [OPW-1:0] OP_NOP   = 4'hE,
  parameter logic [OPW-1:0] OP_HALT  = 4'hF,
  parameter int             TIMEOUT  = 15,
  parameter int             CNTW     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [OPW-1:0]  opcode,
  input  logic            mem_ready,
  input  logic            resume,
  output logic            en_fetch,
  output logic            en_decode,
  output logic            en_regrd,
  output logic            en_alu,
  output logic            en_mem,
  output logic            en_regwr,
  output logic            halted,
  output logic [2:0]      state,
  output logic            err,
  output logic            instr_done,
  output logic [CNTW-1:0] instr_count
);

  // The counter never needs to exceed TIMEOUT-1: at that value the FSM halts instead.
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_REGRD  = 3'd2,
    S_ALU    = 3'd3,
    S_MEM    = 3'd4,
    S_REGWR  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    C_ALU   = 2'd0,
    C_LOAD  = 2'd1,
    C_STORE = 2'd2
  } cls_t;

  state_t         state_q, state_d;
  cls_t           cls_q, cls_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           err_d;
  logic           retire;
  logic           timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WCW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    wait_d  = wait_q;
    err_d   = err;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_DECODE: begin
        if (opcode == OP_LOAD)       cls_d = C_LOAD;
        else if (opcode == OP_STORE) cls_d = C_STORE;
        else                         cls_d = C_ALU;
        if (opcode == OP_NOP) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else begin
          state_d = S_REGRD;
        end
      end
      S_REGRD: state_d = S_ALU;
      S_ALU: begin
        if (cls_q == C_LOAD || cls_q == C_STORE) state_d = S_MEM;
        else                                     state_d = S_REGWR;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (cls_q == C_LOAD) begin
            state_d = S_REGWR;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_REGWR: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT: begin
        if (resume) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Every entry into a waiting state starts a fresh timeout window.
    if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM)) wait_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      cls_q       <= C_ALU;
      wait_q      <= '0;
      err         <= 1'b0;
      instr_done  <= 1'b0;
      instr_count <= '0;
    end else if (stall) begin
      instr_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      wait_q     <= wait_d;
      err        <= err_d;
      instr_done <= retire;
      if (retire) instr_count <= instr_count + CNTW'(1);
    end
  end

  assign state     = state_q;
  assign en_fetch  = (state_q == S_FETCH);
  assign en_decode = (state_q == S_DECODE);
  assign en_regrd  = (state_q == S_REGRD) || (state_q == S_REGWR);
  assign en_alu    = (state_q == S_ALU);
  assign en_mem    = (state_q == S_MEM);
  assign en_regwr  = (state_q == S_REGWR);
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Bench for multicycle_seq_ctrl: directed literal sequences, then randomized traffic against a route-queue model.
module tb_multicycle_seq_ctrl;
  localparam int CW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1, stall = 1'b0, mem_ready = 1'b0, resume = 1'b0;
  logic [3:0]    opcode = 4'h0;
  logic          en_fetch, en_decode, en_regrd, en_alu, en_mem, en_regwr, halted, err, instr_done;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  multicycle_seq_ctrl #(.CNTW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall(stall), .opcode(opcode), .mem_ready(mem_ready), .resume(resume),
    .en_fetch(en_fetch), .en_decode(en_decode), .en_regrd(en_regrd), .en_alu(en_alu),
    .en_mem(en_mem), .en_regwr(en_regwr), .halted(halted), .state(state), .err(err),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: current state, the remaining stages of the instruction in flight, wait count, flags.
  int m_state = 0, m_wait = 0, m_err = 0, m_done = 0, m_cnt = 0;
  int route[$];

  int e_alu[5]  = '{1, 2, 3, 5, 0};
  int e_ld[9]   = '{1, 2, 3, 4, 4, 4, 4, 5, 0};
  int mr_ld[9]  = '{1, 1, 1, 1, 0, 0, 0, 1, 1};
  int e_st[5]   = '{1, 2, 3, 4, 0};

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_instr(output int nxt, output bit ret);
    if (route.size() == 0) begin
      nxt = 0;
      ret = 1'b1;
    end else begin
      nxt = route.pop_front();
      ret = 1'b0;
    end
  endtask

  task automatic model_step();
    int nxt;
    bit ret;
    nxt = m_state;
    ret = 1'b0;
    if (rst) begin
      m_state = 0; m_wait = 0; m_err = 0; m_done = 0; m_cnt = 0;
      route.delete();
      return;
    end
    if (stall) begin
      m_done = 0;
      return;
    end
    case (m_state)
      0, 4: begin
        if (mem_ready) begin
          if (m_state == 0) nxt = 1;
          else finish_instr(nxt, ret);
        end else if (m_wait == TO - 1) begin
          nxt = 6;
          m_err = 1;
        end else begin
          m_wait++;
        end
      end
      1: begin
        if (opcode == 4'hE) begin
          nxt = 0; ret = 1'b1;
        end else if (opcode == 4'hF) begin
          nxt = 6; ret = 1'b1;
        end else begin
          route.delete();
          route.push_back(3);
          if (opcode == 4'h8) begin
            route.push_back(4); route.push_back(5);
          end else if (opcode == 4'h9) begin
            route.push_back(4);
          end else begin
            route.push_back(5);
          end
          nxt = 2;
        end
      end
      2, 3, 5: finish_instr(nxt, ret);
      6: if (resume) nxt = 0;
      default: nxt = 0;
    endcase
    if (nxt != m_state && (nxt == 0 || nxt == 4)) m_wait = 0;
    m_state = nxt;
    m_done = ret;
    if (ret) m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("state", state, m_state);
      cmp("en_fetch", en_fetch, m_state == 0);
      cmp("en_decode", en_decode, m_state == 1);
      cmp("en_regrd", en_regrd, m_state == 2 || m_state == 5);
      cmp("en_alu", en_alu, m_state == 3);
      cmp("en_mem", en_mem, m_state == 4);
      cmp("en_regwr", en_regwr, m_state == 5);
      cmp("halted", halted, m_state == 6);
      cmp("err", err, m_err);
      cmp("instr_done", instr_done, m_done);
      cmp("instr_count", instr_count, m_cnt);
    end
  end

  task automatic step(input logic r, input logic s, input logic m, input logic u, input logic [3:0] o);
    rst = r; stall = s; mem_ready = m; resume = u; opcode = o;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int dry;
    int pick;
    logic [3:0] op;
    dry = 0;

    step(1, 0, 0, 0, 4'h0);
    chk_en = 1'b1;
    cmp("rst_state", state, 0);
    cmp("rst_count", instr_count, 0);
    cmp("rst_err", err, 0);
    cmp("rst_done", instr_done, 0);

    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 4'h1);
      cmp("alu_seq", state, e_alu[i]);
      cmp("alu_regrd", en_regrd, (i == 1 || i == 3));
    end
    cmp("alu_done", instr_done, 1);
    cmp("alu_count", instr_count, 1);

    for (int i = 0; i < 9; i++) begin
      step(0, 0, mr_ld[i][0], 0, 4'h8);
      cmp("load_seq", state, e_ld[i]);
    end
    cmp("load_count", instr_count, 2);

    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 4'h9);
      cmp("store_seq", state, e_st[i]);
    end
    cmp("store_count", instr_count, 3);

    step(0, 0, 1, 0, 4'hE);
    step(0, 0, 1, 0, 4'hE);
    cmp("nop_state", state, 0);
    cmp("nop_done", instr_done, 1);
    cmp("nop_count", instr_count, 4);

    step(0, 0, 1, 0, 4'hF);
    step(0, 0, 1, 0, 4'hF);
    cmp("halt_state", state, 6);
    step(0, 0, 1, 0, 4'hF);
    step(0, 0, 1, 0, 4'hF);
    cmp("halt_hold", halted, 1);
    step(0, 0, 1, 1, 4'hF);
    cmp("resume_state", state, 0);
    cmp("resume_err", err, 0);
    cmp("halt_count", instr_count, 5);

    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 4'h1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 0, 4'h1);
      cmp("stall_state", state, 3);
      cmp("stall_done", instr_done, 0);
    end
    step(0, 0, 1, 0, 4'h1);
    cmp("post_stall", state, 5);
    step(0, 0, 1, 0, 4'h1);
    cmp("post_stall_count", instr_count, 6);

    for (int i = 1; i <= 15; i++) begin
      step(0, 0, 0, 0, 4'h1);
      cmp("timeout_seq", state, (i == 15) ? 6 : 0);
    end
    cmp("timeout_err", err, 1);
    cmp("timeout_count", instr_count, 6);
    step(0, 0, 0, 1, 4'h1);
    cmp("timeout_resume", state, 0);
    cmp("timeout_err_kept", err, 1);
    step(1, 0, 0, 0, 4'h1);
    cmp("rst_clears_err", err, 0);
    cmp("rst_clears_count", instr_count, 0);

    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 4'h8);
    cmp("in_mem", state, 4);
    step(1, 0, 1, 0, 4'h8);
    cmp("mem_rst_state", state, 0);
    cmp("mem_rst_done", instr_done, 0);
    cmp("mem_rst_count", instr_count, 0);

    for (int i = 0; i < 17; i++) begin
      step(0, 0, 1, 0, 4'hE);
      step(0, 0, 1, 0, 4'hE);
    end
    cmp("wrap_count", instr_count, 1);

    for (int n = 0; n < 4000; n++) begin
      pick = $urandom_range(0, 9);
      if (pick <= 2) begin
        op = 4'($urandom_range(0, 7));
      end else if (pick <= 4) begin
        op = 4'h8;
      end else if (pick <= 6) begin
        op = 4'h9;
      end else if (pick <= 8) begin
        op = 4'hE;
      end else begin
        op = 4'hF;
      end
      if (dry == 0 && $urandom_range(0, 149) == 0) dry = 18;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) == 0),
           (dry > 0) ? 1'b0 : ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), op);
      if (dry > 0) dry--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multicycle_seq_ctrl.md
Name: multicycle_seq_ctrl

Overview:
- Parametrised multicycle control sequencer for the RISC processor datapath.
- Advances each instruction through FETCH/DECODE/REGRD/ALU/MEM/REGWR, using only the states its opcode class needs.
- Waits on a memory ready handshake, supports a global stall, halts on a HALT opcode or memory timeout, and counts retired instructions.
- Sits between the instruction/data memory interface and the datapath enable inputs.

Parameters:
- OPW, 4, opcode width.
- OP_LOAD, 4'h8, load opcode: uses MEM then REGWR.
- OP_STORE, 4'h9, store opcode: uses MEM, no REGWR.
- OP_NOP, 4'hE, no-op: retires straight after DECODE.
- OP_HALT, 4'hF, halt opcode.
- TIMEOUT, 15, maximum wait cycles in FETCH/MEM before error halt; 0 disables the timeout.
- CNTW, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  freezes the FSM, wait counter and retire logic.
- opcode  in  OPW  current instruction opcode; valid while en_decode=1.
- mem_ready  in  1  memory has completed the access in FETCH or MEM.
- resume  in  1  leaves HALT.
- en_fetch  out  1  high in FETCH.
- en_decode  out  1  high in DECODE.
- en_regrd  out  1  high in REGRD and REGWR.
- en_alu  out  1  high in ALU.
- en_mem  out  1  high in MEM.
- en_regwr  out  1  high in REGWR.
- halted  out  1  high in HALT.
- state  out  3  FSM state code.
- err  out  1  sticky timeout flag.
- instr_done  out  1  one-cycle retire pulse, registered.
- instr_count  out  CNTW  retired-instruction count.

Behaviour:
- Clock is clk. Reset rst is synchronous, active-high.
- Reset: state=FETCH, wait_cnt=0, opcode class=ALU, err=0, instr_done=0, instr_count=0.
- Enable and status outputs (en_*, halted, state) are Moore: combinational from the state register only.
- State codes: FETCH=0, DECODE=1, REGRD=2, ALU=3, MEM=4, REGWR=5, HALT=6.
- Code 7 is illegal; the FSM goes to FETCH on the next clock.
- Priority each clock: rst > stall > transition logic.
- While stall=1, state, wait_cnt, err and instr_count hold, and instr_done=0.
- FETCH: mem_ready=1 -> DECODE.
- DECODE: opcode is latched into a class register.
  - OP_NOP -> FETCH, retire.
  - OP_HALT -> HALT, retire.
  - Any other opcode -> REGRD.
- REGRD -> ALU unconditionally.
- ALU: load or store class -> MEM; otherwise -> REGWR.
- MEM, mem_ready=1: load -> REGWR; store -> FETCH, retire.
- REGWR -> FETCH, retire.
- HALT: resume=1 -> FETCH; otherwise stay. Resuming does not clear err.
- Wait counter (FETCH/MEM only):
  - Cleared on every transition into FETCH or MEM.
  - Increments each unstalled cycle with mem_ready=0.
  - If mem_ready=0 and wait_cnt==TIMEOUT-1 (TIMEOUT>0): next state=HALT, err<=1, no retire.
  - mem_ready=1 in the same cycle beats the timeout.
- Retire: instr_done=1 for exactly the cycle after a retiring transition, and instr_count increments by 1 on the same clock.
- instr_count wraps from 2^CNTW-1 to 0.
- Reset mid-instruction aborts it: no retire, counters zeroed.

Test Plan:
- ALU op 4'h1, mem_ready=1 throughout -> states 0,1,2,3,5,0 (5 cycles per instruction); en_regrd high in states 2 and 5; instr_done pulses once; instr_count=1.
- Load 4'h8 with mem_ready low for 3 cycles in MEM -> MEM held for 4 cycles, then REGWR, then FETCH; instr_count +1. Store 4'h9 -> MEM then FETCH, no REGWR cycle.
- NOP 4'hE -> FETCH, DECODE, FETCH; instr_done pulses. HALT 4'hF -> halted=1 and held with resume=0; resume=1 -> FETCH; err=0.
- mem_ready held 0 in FETCH with TIMEOUT=15 -> HALT after exactly 15 FETCH cycles; err=1; instr_count unchanged; resume -> FETCH with err still 1; rst -> err=0.
- stall=1 for 4 cycles during ALU -> state stays 3, no instr_done; the sequence continues normally after stall drops.
- CNTW=4: retire 17 instructions -> instr_count=1. rst asserted in MEM -> next state FETCH, counters 0, no instr_done.
